// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order prediction tracking queue and resolve/update unit
// Pairs fetch predictions with EX outcomes; emits predictor updates, redirects and statistics.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int IDX_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pred_valid,
   input  logic [PC_W-1:0]              pred_pc,
   input  logic                         pred_taken,
   input  logic [PC_W-1:0]              pred_target,
   output logic                         pred_ready,
   input  logic                         res_valid,
   input  logic                         res_taken,
   input  logic [PC_W-1:0]              res_target,
   input  logic                         res_is_jump,
   output logic                         upd_valid,
   output logic [IDX_W-1:0]             upd_address,
   output logic                         upd_taken,
   output logic                         mispredict,
   output logic [PC_W-1:0]              redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [31:0]                  branch_count,
   output logic [31:0]                  mispredict_count,
   output logic                         underflow_err
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [PC_W-1:0]  pc_mem_q   [DEPTH];
   logic             tk_mem_q   [DEPTH];
   logic [PC_W-1:0]  tgt_mem_q  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             upd_valid_q, upd_taken_q, mispredict_q, underflow_q;
   logic [IDX_W-1:0] upd_address_q;
   logic [PC_W-1:0]  redirect_q;
   logic [31:0]      br_cnt_q, mp_cnt_q;

   logic             push, pop, miss;
   logic [PC_W-1:0]  head_pc, head_tgt, correct_pc;
   logic             head_tk;

   assign pred_ready = (occ_q != OCC_W'(DEPTH));
   assign push       = pred_valid && pred_ready;
   assign pop        = res_valid && (occ_q != '0);

   assign head_pc    = pc_mem_q[rd_ptr_q];
   assign head_tk    = tk_mem_q[rd_ptr_q];
   assign head_tgt   = tgt_mem_q[rd_ptr_q];
   assign correct_pc = res_taken ? res_target : head_pc + PC_W'(4);
   assign miss       = pop && ((res_taken != head_tk) || (res_taken && (head_tgt != res_target)));

   // A miss discards the wrong-path entries and any same-cycle push by snapping rd to wr.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (miss) begin
         rd_ptr_d = wr_ptr_q;
         occ_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]  <= pred_pc;
         tk_mem_q[wr_ptr_q]  <= pred_taken;
         tgt_mem_q[wr_ptr_q] <= pred_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
         upd_valid_q   <= 1'b0;
         upd_address_q <= '0;
         upd_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         redirect_q    <= '0;
         br_cnt_q      <= '0;
         mp_cnt_q      <= '0;
         underflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         upd_valid_q  <= pop && !res_is_jump;
         mispredict_q <= miss;
         if (pop) begin
            upd_address_q <= head_pc[IDX_W+1:2];
            upd_taken_q   <= res_taken;
         end
         if (miss) redirect_q <= correct_pc;
         if (pop && !res_is_jump && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
         if (miss && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 32'd1;
         if (res_valid && (occ_q == '0)) underflow_q <= 1'b1;
      end
   end

   assign upd_valid        = upd_valid_q;
   assign upd_address      = upd_address_q;
   assign upd_taken        = upd_taken_q;
   assign mispredict       = mispredict_q;
   assign redirect_pc      = redirect_q;
   assign occupancy        = occ_q;
   assign branch_count     = br_cnt_q;
   assign mispredict_count = mp_cnt_q;
   assign underflow_err    = underflow_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vector bench for branch_resolve_unit
module tb_branch_resolve_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid, pred_taken, pred_ready;
   logic [31:0] pred_pc, pred_target;
   logic        res_valid, res_taken, res_is_jump;
   logic [31:0] res_target;
   logic        upd_valid, upd_taken, mispredict, underflow_err;
   logic [7:0]  upd_address;
   logic [31:0] redirect_pc, branch_count, mispredict_count;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;
   int exp_br = 0;
   int exp_mp = 0;
   logic [31:0] exp_redir = 32'h0;
   logic [31:0] model_q[$];
   logic [31:0] hp;

   typedef struct {
      logic [31:0] pc; logic ptk; logic [31:0] ptgt;
      logic rtk; logic [31:0] rtgt; logic jmp;
      logic ev; logic [7:0] ea; logic et; logic em; logic [31:0] er;
   } vec_t;
   vec_t vecs[7];

   branch_resolve_unit #(.DEPTH(4), .PC_W(32), .IDX_W(8)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .res_is_jump(res_is_jump),
      .upd_valid(upd_valid), .upd_address(upd_address), .upd_taken(upd_taken),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .occupancy(occupancy),
      .branch_count(branch_count), .mispredict_count(mispredict_count),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt;
      tick();
      pred_valid = 1'b0;
   endtask

   task automatic set_res(input logic tk, input logic [31:0] tgt, input logic jmp);
      res_valid = 1'b1; res_taken = tk; res_target = tgt; res_is_jump = jmp;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_occ"}, 32'(occupancy), 32'd0);
      check({tag, "_ready"}, 32'(pred_ready), 32'd1);
      check({tag, "_updv"}, 32'(upd_valid), 32'd0);
      check({tag, "_upda"}, 32'(upd_address), 32'd0);
      check({tag, "_updt"}, 32'(upd_taken), 32'd0);
      check({tag, "_mp"}, 32'(mispredict), 32'd0);
      check({tag, "_redir"}, redirect_pc, 32'd0);
      check({tag, "_brcnt"}, branch_count, 32'd0);
      check({tag, "_mpcnt"}, mispredict_count, 32'd0);
      check({tag, "_uflow"}, 32'(underflow_err), 32'd0);
   endtask

   initial begin
      //          pc            ptk ptgt          rtk rtgt          jmp ev  ea     et  em  er
      vecs[0] = '{32'h0000_0100, 0, 32'h0,        0, 32'h0,        0, 1, 8'h40, 0, 0, 32'h0};
      vecs[1] = '{32'h0000_03FC, 1, 32'h80,       0, 32'h0,        0, 1, 8'hFF, 0, 1, 32'h400};
      vecs[2] = '{32'h0000_0010, 1, 32'h40,       1, 32'h44,       1, 0, 8'h04, 1, 1, 32'h44};
      vecs[3] = '{32'h0000_0500, 1, 32'h600,      1, 32'h600,      0, 1, 8'h40, 1, 0, 32'h44};
      vecs[4] = '{32'hFFFF_FFFC, 1, 32'h0,        0, 32'h0,        0, 1, 8'hFF, 0, 1, 32'h0};
      vecs[5] = '{32'h0000_0204, 0, 32'h0,        1, 32'h300,      0, 1, 8'h81, 1, 1, 32'h300};
      vecs[6] = '{32'h0000_0020, 1, 32'h80,       1, 32'h80,       1, 0, 8'h08, 1, 0, 32'h300};

      rst = 1'b1; pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0; res_is_jump = 0;
      #12;
      check_reset_state("por");
      rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         push(vecs[i].pc, vecs[i].ptk, vecs[i].ptgt);
         check($sformatf("v%0d_occ1", i), 32'(occupancy), 32'd1);
         set_res(vecs[i].rtk, vecs[i].rtgt, vecs[i].jmp);
         tick();
         res_valid = 1'b0;
         exp_br += int'(vecs[i].ev);
         exp_mp += int'(vecs[i].em);
         check($sformatf("v%0d_updv", i), 32'(upd_valid), 32'(vecs[i].ev));
         check($sformatf("v%0d_upda", i), 32'(upd_address), 32'(vecs[i].ea));
         check($sformatf("v%0d_updt", i), 32'(upd_taken), 32'(vecs[i].et));
         check($sformatf("v%0d_mp", i), 32'(mispredict), 32'(vecs[i].em));
         check($sformatf("v%0d_redir", i), redirect_pc, vecs[i].er);
         check($sformatf("v%0d_brcnt", i), branch_count, 32'(exp_br));
         check($sformatf("v%0d_mpcnt", i), mispredict_count, 32'(exp_mp));
         check($sformatf("v%0d_occ0", i), 32'(occupancy), 32'd0);
         tick();
         check($sformatf("v%0d_updv_drop", i), 32'(upd_valid), 32'd0);
         check($sformatf("v%0d_mp_drop", i), 32'(mispredict), 32'd0);
         check($sformatf("v%0d_redir_hold", i), redirect_pc, vecs[i].er);
      end
      exp_redir = 32'h300;

      // Direction miss with a younger entry behind it and a same-cycle push: all flushed.
      push(32'h200, 1'b0, 32'h0);
      push(32'h204, 1'b0, 32'h0);
      check("dm_occ2", 32'(occupancy), 32'd2);
      set_res(1'b1, 32'h300, 1'b0);
      pred_valid = 1'b1; pred_pc = 32'h208; pred_taken = 1'b0;
      tick();
      res_valid = 1'b0; pred_valid = 1'b0;
      exp_br++; exp_mp++;
      check("dm_mp", 32'(mispredict), 32'd1);
      check("dm_redir", redirect_pc, 32'h300);
      check("dm_upda", 32'(upd_address), 32'h80);
      check("dm_occ", 32'(occupancy), 32'd0);
      check("dm_mpcnt", mispredict_count, 32'(exp_mp));

      // Fill, overflow attempt, then streaming push+pop across pointer wrap.
      for (int k = 0; k < 4; k++) begin
         push(32'h1000 + 32'(4 * k), 1'b0, 32'h0);
         model_q.push_back(32'h1000 + 32'(4 * k));
      end
      check("full_ready", 32'(pred_ready), 32'd0);
      check("full_occ", 32'(occupancy), 32'd4);
      push(32'h1FF0, 1'b0, 32'h0);
      check("full_drop_occ", 32'(occupancy), 32'd4);
      for (int k = 0; k < 11; k++) begin
         set_res(1'b0, 32'h0, 1'b0);
         if (k > 0) begin
            pred_valid = 1'b1; pred_pc = 32'h2000 + 32'(4 * k); pred_taken = 1'b0;
            model_q.push_back(32'h2000 + 32'(4 * k));
         end
         tick();
         res_valid = 1'b0; pred_valid = 1'b0;
         hp = model_q.pop_front();
         exp_br++;
         check($sformatf("stream%0d_upda", k), 32'(upd_address), 32'(hp[9:2]));
         check($sformatf("stream%0d_mp", k), 32'(mispredict), 32'd0);
         check($sformatf("stream%0d_occ", k), 32'(occupancy), 32'd3);
      end
      while (model_q.size() > 0) begin
         set_res(1'b0, 32'h0, 1'b0);
         tick();
         res_valid = 1'b0;
         hp = model_q.pop_front();
         exp_br++;
         check("drain_upda", 32'(upd_address), 32'(hp[9:2]));
      end
      check("drain_occ", 32'(occupancy), 32'd0);
      check("drain_brcnt", branch_count, 32'(exp_br));

      set_res(1'b1, 32'h900, 1'b0);
      tick();
      res_valid = 1'b0;
      check("uf_err", 32'(underflow_err), 32'd1);
      check("uf_updv", 32'(upd_valid), 32'd0);
      check("uf_mp", 32'(mispredict), 32'd0);
      check("uf_brcnt", branch_count, 32'(exp_br));
      check("uf_redir", redirect_pc, exp_redir);
      tick(); tick();
      check("uf_sticky", 32'(underflow_err), 32'd1);

      // Asynchronous reset between edges with entries outstanding.
      push(32'h3000, 1'b0, 32'h0);
      push(32'h3004, 1'b0, 32'h0);
      push(32'h3008, 1'b0, 32'h0);
      check("mr_occ3", 32'(occupancy), 32'd3);
      #3 rst = 1'b1;
      #1;
      check_reset_state("midrst");
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_occ", 32'(occupancy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Producer side of the gshare predictor's update interface.
- Records every prediction issued at fetch in an in-order tracking queue. Compares it with the actual outcome when the branch/jump resolves in EX.
- Drives a one-cycle predictor update pulse (address, taken), plus mispredict/redirect to the fetch stage.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- DEPTH, 4, tracking-queue entries (power of two, ≥2)
- PC_W, 32, program-counter width
- IDX_W, 8, predictor index width; index = pc[IDX_W+1:2]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pred_valid  in  1  fetch issues a prediction for a control-flow instruction
- pred_pc  in  PC_W  PC of predicted instruction
- pred_taken  in  1  predicted direction
- pred_target  in  PC_W  predicted target (meaningful when pred_taken=1)
- pred_ready  out  1  queue not full
- res_valid  in  1  EX resolves the oldest outstanding control-flow instruction
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- res_is_jump  in  1  resolving instruction is JAL/JALR (no direction-table update)
- upd_valid  out  1  predictor update strobe, one cycle
- upd_address  out  IDX_W  predictor update address
- upd_taken  out  1  actual direction for update
- mispredict  out  1  flush/redirect strobe, one cycle
- redirect_pc  out  PC_W  correct next PC, valid with mispredict
- occupancy  out  clog2(DEPTH+1)  entries held
- branch_count  out  32  resolved conditional branches
- mispredict_count  out  32  resolved mispredictions (branches and jumps)
- underflow_err  out  1  sticky: resolve seen while queue empty

Behaviour:
- Reset (async, any time, including mid-operation):
  - queue emptied; occupancy=0; pred_ready=1
  - upd_valid=0, upd_address=0, upd_taken=0
  - mispredict=0, redirect_pc=0
  - both counters=0; underflow_err=0
- Queue entry = {pc, pred_taken, pred_target}; circular buffer with wrapping read/write pointers.
- Push: pred_valid && pred_ready at clk edge.
- pred_ready = (occupancy != DEPTH), combinational from state only. It does not account for a same-cycle pop.
- pred_valid while full: ignored; no state change.
- Resolve: res_valid && occupancy!=0 pops the head entry and evaluates it. Head entry = E.
  - correct_pc = res_taken ? res_target : E.pc + 4, computed modulo 2^PC_W
  - miss = (res_taken != E.pred_taken) || (res_taken && E.pred_target != res_target)
- All result outputs are registered and valid the cycle after the resolving edge (latency 1). Strobes are high for exactly one cycle.
- Outputs for a resolve:
  - upd_valid = !res_is_jump
  - upd_address = E.pc[IDX_W+1:2]
  - upd_taken = res_taken
  - mispredict = miss; redirect_pc = correct_pc when miss, otherwise holds its previous value
  - branch_count += 1 when !res_is_jump
  - mispredict_count += 1 when miss
  - both counters saturate at 0xFFFFFFFF
- Mispredict flush: on a resolve with miss, all remaining entries are discarded (wrong path). A push in the same cycle is also discarded. occupancy becomes 0 next cycle.
- Simultaneous push and pop without miss: occupancy unchanged; pointers both advance.
- res_valid with empty queue:
  - no pop, no strobes
  - underflow_err set to 1 and held until rst
- No resolve: upd_valid=0, mispredict=0; other outputs hold.

Test Plan:
- Reset mid-traffic: 3 pushes, assert rst asynchronously between edges -> occupancy=0, pred_ready=1, all outputs/counters 0 immediately, without waiting for a clock edge.
- Correct not-taken: push pc=0x100, pred_taken=0; resolve res_taken=0 -> next cycle upd_valid=1, upd_address=0x40, upd_taken=0, mispredict=0, branch_count=1.
- Direction miss: push pc=0x200 pred_taken=0, push 0x204; resolve res_taken=1, res_target=0x300 -> mispredict=1, redirect_pc=0x300, occupancy=0, mispredict_count=1.
- Fall-through miss: pc=0x3FC pred_taken=1 target 0x80; resolve res_taken=0 -> redirect_pc=0x400, upd_taken=0.
- Jump target miss: pc=0x10 pred_taken=1 target 0x40; resolve res_is_jump=1 res_taken=1 res_target=0x44 -> mispredict=1, redirect_pc=0x44, upd_valid=0, branch_count unchanged.
- Full/wrap/underflow:
  - push DEPTH entries -> pred_ready=0; extra push dropped
  - push+pop each cycle for 10 cycles -> order preserved across pointer wrap
  - drain, then res_valid -> underflow_err=1, sticky until rst
